// File: rtl/pcie_tx_arbiter.sv
// Purpose : N-source packet arbiter onto the PCIe shell TX port; source 0 (controller) gets bounded priority, others round-robin.
// Latency : zero-cycle; the selected source's beat is presented combinationally and can transfer in the cycle it is first valid.
// Backpr. : pcie_grant_in low stalls everything; only the selected source ever sees src_ready, and a started packet holds the port until last.
//
// Ports: clk/rst_n (async active-low); src_valid/src_last/src_pad/src_slot/src_data per-source beat inputs;
//        src_ready per-source accept; pcie_out_* muxed beat; pcie_grant_in shell accept;
//        sent_pkt_count per-source 32-bit completed-packet counters; busy high while a packet holds the port.
module pcie_tx_arbiter #(
    parameter int N_SRC    = 4,
    parameter int HP_QUOTA = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_SRC-1:0]     src_valid,
    input  logic [N_SRC-1:0]     src_last,
    input  logic [N_SRC*4-1:0]   src_pad,
    input  logic [N_SRC*16-1:0]  src_slot,
    input  logic [N_SRC*128-1:0] src_data,
    output logic [N_SRC-1:0]     src_ready,
    output logic                 pcie_out_valid,
    output logic                 pcie_out_last,
    output logic [3:0]           pcie_out_pad,
    output logic [15:0]          pcie_out_slot,
    output logic [127:0]         pcie_out_data,
    input  logic                 pcie_grant_in,
    output logic [N_SRC*32-1:0]  sent_pkt_count,
    output logic                 busy
);

    localparam int IDX_W = $clog2(N_SRC);

    typedef enum logic {IDLE, LOCK} state_t;

    typedef struct packed {
        logic         last;
        logic [3:0]   pad;
        logic [15:0]  slot;
        logic [127:0] dat;
    } beat_t;

    state_t                     state_q, state_d;
    logic [IDX_W-1:0]           lock_sel_q, lock_sel_d;
    logic [IDX_W-1:0]           rr_ptr_q, rr_ptr_d;
    logic [3:0]                 hp_cnt_q, hp_cnt_d;
    logic [N_SRC-1:0][31:0]     pkt_cnt;

    logic [IDX_W-1:0]           sel;
    logic                       sel_vld;
    logic                       fallback;
    logic [IDX_W-1:0]           rr_pick;
    logic                       rr_hit;
    logic                       xfer;
    logic                       done;
    beat_t                      out_beat;

    // Circular search over sources 1..N_SRC-1 starting at rr_ptr. The loop
    // runs from the farthest offset down so the nearest valid source wins.
    always_comb begin
        int idx;
        rr_hit  = 1'b0;
        rr_pick = '0;
        idx     = 0;
        for (int off = N_SRC - 2; off >= 0; off--) begin
            idx = 1 + ((int'(rr_ptr_q) - 1 + off) % (N_SRC - 1));
            if (src_valid[idx]) begin
                rr_hit  = 1'b1;
                rr_pick = IDX_W'(idx);
            end
        end
    end

    // Selection: a locked packet always owns the port. In IDLE source 0 wins
    // until it has used its quota; then the round-robin sources get a turn.
    // Source 0 under an exhausted quota is still served when nobody else
    // wants the port (fallback), which restarts its quota.
    always_comb begin
        sel      = '0;
        sel_vld  = 1'b0;
        fallback = 1'b0;
        if (state_q == LOCK) begin
            sel     = lock_sel_q;
            sel_vld = 1'b1;
        end else if (src_valid[0] && (hp_cnt_q < 4'(HP_QUOTA))) begin
            sel_vld = 1'b1;
        end else if (rr_hit) begin
            sel     = rr_pick;
            sel_vld = 1'b1;
        end else if (src_valid[0]) begin
            sel_vld  = 1'b1;
            fallback = 1'b1;
        end
    end

    // Output mux; rst_n gates the handshake so nothing moves while in reset.
    always_comb begin
        out_beat.last = src_last[sel];
        out_beat.pad  = src_pad[sel*4 +: 4];
        out_beat.slot = src_slot[sel*16 +: 16];
        out_beat.dat  = src_data[sel*128 +: 128];
    end

    assign pcie_out_valid = rst_n & sel_vld & src_valid[sel];
    assign pcie_out_last  = out_beat.last;
    assign pcie_out_pad   = out_beat.pad;
    assign pcie_out_slot  = out_beat.slot;
    assign pcie_out_data  = out_beat.dat;

    assign xfer = pcie_out_valid & pcie_grant_in;
    assign done = xfer & out_beat.last;

    always_comb begin
        src_ready      = '0;
        src_ready[sel] = xfer;
    end

    always_comb begin
        state_d    = state_q;
        lock_sel_d = lock_sel_q;
        rr_ptr_d   = rr_ptr_q;
        hp_cnt_d   = hp_cnt_q;
        if (xfer) begin
            if (state_q == IDLE && !out_beat.last) begin
                state_d    = LOCK;
                lock_sel_d = sel;
            end
            if (state_q == LOCK && out_beat.last) begin
                state_d = IDLE;
            end
            // A fallback grant restarts the quota before this packet is counted.
            if (fallback) begin
                hp_cnt_d = '0;
            end
            if (done) begin
                if (sel == '0) begin
                    if (hp_cnt_d < 4'(HP_QUOTA)) begin
                        hp_cnt_d = hp_cnt_d + 4'd1;
                    end
                end else begin
                    hp_cnt_d = '0;
                    rr_ptr_d = (sel == IDX_W'(N_SRC - 1)) ? IDX_W'(1) : sel + IDX_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            lock_sel_q <= '0;
            rr_ptr_q   <= IDX_W'(1);
            hp_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            lock_sel_q <= lock_sel_d;
            rr_ptr_q   <= rr_ptr_d;
            hp_cnt_q   <= hp_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt <= '0;
        end else begin
            for (int i = 0; i < N_SRC; i++) begin
                if (done && sel == IDX_W'(i)) begin
                    pkt_cnt[i] <= pkt_cnt[i] + 32'd1;
                end
            end
        end
    end

    assign sent_pkt_count = pkt_cnt;
    assign busy           = (state_q == LOCK);

endmodule

// File: tb/tb_pcie_tx_arbiter.sv
// Purpose : self-checking bench for pcie_tx_arbiter using per-source beat queues and an expected-order scoreboard.
// Latency : one step() per clock; monitor samples on the falling edge, stimulus changes 1 ns after the rising edge.
// Backpr. : pcie_grant_in is driven by the bench; sources pop a beat only when src_ready was seen high.
module tb_pcie_tx_arbiter;

    localparam int N = 4;

    typedef struct {
        logic         last;
        logic [127:0] data;
    } sbeat_t;

    typedef struct {
        int           src;
        logic         last;
        logic [127:0] data;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [N-1:0]       src_valid = '0;
    logic [N-1:0]       src_last = '0;
    logic [N*4-1:0]     src_pad = '0;
    logic [N*16-1:0]    src_slot = '0;
    logic [N*128-1:0]   src_data = '0;
    logic [N-1:0]       src_ready;
    logic               pcie_out_valid;
    logic               pcie_out_last;
    logic [3:0]         pcie_out_pad;
    logic [15:0]        pcie_out_slot;
    logic [127:0]       pcie_out_data;
    logic               pcie_grant_in = 1'b1;
    logic [N*32-1:0]    sent_pkt_count;
    logic               busy;

    int checks = 0;
    int errors = 0;

    sbeat_t       sq[N][$];
    exp_t         exp_q[$];
    logic [N-1:0] en = '0;

    pcie_tx_arbiter #(.N_SRC(N), .HP_QUOTA(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .src_valid(src_valid), .src_last(src_last), .src_pad(src_pad),
        .src_slot(src_slot), .src_data(src_data), .src_ready(src_ready),
        .pcie_out_valid(pcie_out_valid), .pcie_out_last(pcie_out_last),
        .pcie_out_pad(pcie_out_pad), .pcie_out_slot(pcie_out_slot),
        .pcie_out_data(pcie_out_data), .pcie_grant_in(pcie_grant_in),
        .sent_pkt_count(sent_pkt_count), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] mk_data(int src, int pkt, int beat);
        return {104'h0, 8'(src), 8'(pkt), 8'(beat)};
    endfunction

    // Queue a packet at a source and record its beats in the expected stream.
    task automatic add_pkt(int src, int pkt, int nbeats, bit expect_now);
        for (int b = 0; b < nbeats; b++) begin
            sbeat_t s;
            s.last = (b == nbeats - 1);
            s.data = mk_data(src, pkt, b);
            sq[src].push_back(s);
            if (expect_now) begin
                exp_t e;
                e.src  = src;
                e.last = s.last;
                e.data = s.data;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (en[i] && sq[i].size() > 0) begin
                src_valid[i]           = 1'b1;
                src_last[i]            = sq[i][0].last;
                src_data[i*128 +: 128] = sq[i][0].data;
                src_pad[i*4 +: 4]      = sq[i][0].data[3:0];
                src_slot[i*16 +: 16]   = sq[i][0].data[23:8];
            end else begin
                src_valid[i] = 1'b0;
                src_last[i]  = 1'b0;
            end
        end
    endtask

    // One clock: scoreboard compare on the falling edge, then retire accepted beats.
    task automatic step();
        logic [N-1:0] rdy;
        logic [N-1:0] oh;
        exp_t         e;
        @(negedge clk);
        rdy = src_ready;
        if (pcie_out_valid && pcie_grant_in) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat data=%h ready=%b expected no beat", pcie_out_data, src_ready);
            end else begin
                e = exp_q.pop_front();
                oh = '0;
                oh[e.src] = 1'b1;
                if (pcie_out_data !== e.data || pcie_out_last !== e.last ||
                    pcie_out_pad !== e.data[3:0] || pcie_out_slot !== e.data[23:8] ||
                    src_ready !== oh) begin
                    errors++;
                    $display("FAIL beat got data=%h last=%b pad=%h slot=%h ready=%b expected data=%h last=%b ready=%b",
                             pcie_out_data, pcie_out_last, pcie_out_pad, pcie_out_slot, src_ready,
                             e.data, e.last, oh);
                end
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (rdy[i] && sq[i].size() > 0) sq[i].delete(0);
        end
        drive();
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) sq[i].delete();
        exp_q.delete();
        en = '0;
        drive();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        pcie_grant_in = 1'b1;
        clear_all();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic check_drained(string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain got %0d beats outstanding expected 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_all();
        for (int s = 0; s < N; s++) add_pkt(s, 0, 1, 1'b0);
        en = '1;
        drive();
        #1;
        checks++;
        if (src_ready !== '0 || pcie_out_valid !== 1'b0 || busy !== 1'b0 || sent_pkt_count !== '0) begin
            errors++;
            $display("FAIL reset_outputs got ready=%b valid=%b busy=%b cnt=%h expected 0/0/0/0",
                     src_ready, pcie_out_valid, busy, sent_pkt_count);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        // Quota not used yet: controller first, then 1,2,3 round-robin.
        for (int s = 0; s < N; s++) add_pkt(s, 0, 0, 1'b0);
        begin
            exp_t e;
            for (int s = 0; s < N; s++) begin
                e.src = s; e.last = 1'b1; e.data = mk_data(s, 0, 0);
                exp_q.push_back(e);
            end
        end
        checks++;
        if (pcie_out_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_grant got valid=%b expected 1", pcie_out_valid);
        end
        for (int c = 0; c < 4; c++) step();
        check_drained("reset");
    endtask

    task automatic test_lock();
        do_reset();
        add_pkt(1, 1, 3, 1'b1);
        add_pkt(2, 1, 1, 1'b1);
        en = 4'b0010;
        drive();
        step();
        en = 4'b0110;
        drive();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL lock_busy got %b expected 1", busy);
        end
        for (int c = 0; c < 3; c++) step();
        check_drained("lock");
        checks++;
        if (sent_pkt_count[32 +: 32] !== 32'd1 || sent_pkt_count[64 +: 32] !== 32'd1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL lock_counts got c1=%0d c2=%0d busy=%b expected 1 1 0",
                     sent_pkt_count[32 +: 32], sent_pkt_count[64 +: 32], busy);
        end
    endtask

    task automatic test_hp_quota();
        do_reset();
        for (int p = 0; p < 4; p++) add_pkt(0, p, 1, 1'b1);
        add_pkt(3, 0, 1, 1'b1);
        for (int p = 4; p < 6; p++) add_pkt(0, p, 1, 1'b1);
        en = 4'b1001;
        drive();
        for (int c = 0; c < 5; c++) step();
        checks++;
        if (dut.hp_cnt_q !== 4'd0) begin
            errors++;
            $display("FAIL hp_clear got %0d expected 0", dut.hp_cnt_q);
        end
        for (int c = 0; c < 2; c++) step();
        check_drained("hp_quota");
        checks++;
        if (dut.hp_cnt_q !== 4'd2 || sent_pkt_count[0 +: 32] !== 32'd6 || sent_pkt_count[96 +: 32] !== 32'd1) begin
            errors++;
            $display("FAIL hp_counts got hp=%0d c0=%0d c3=%0d expected 2 6 1",
                     dut.hp_cnt_q, sent_pkt_count[0 +: 32], sent_pkt_count[96 +: 32]);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int p = 0; p < 2; p++) begin
            for (int s = 1; s < N; s++) add_pkt(s, p, 1, 1'b1);
        end
        en = 4'b1110;
        drive();
        for (int c = 0; c < 6; c++) step();
        check_drained("round_robin");
        checks++;
        if (sent_pkt_count !== {32'd2, 32'd2, 32'd2, 32'd0}) begin
            errors++;
            $display("FAIL rr_counts got %h expected %h", sent_pkt_count, {32'd2, 32'd2, 32'd2, 32'd0});
        end
    endtask

    task automatic test_grant_stall();
        logic [127:0] held;
        do_reset();
        add_pkt(2, 7, 4, 1'b1);
        add_pkt(1, 7, 1, 1'b1);
        en = 4'b0100;
        drive();
        step();
        en = 4'b0110;
        drive();
        step();
        pcie_grant_in = 1'b0;
        held = mk_data(2, 7, 2);
        for (int c = 0; c < 5; c++) begin
            step();
            checks++;
            if (src_ready !== '0 || pcie_out_valid !== 1'b1 || pcie_out_data !== held || busy !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold cyc=%0d got ready=%b valid=%b data=%h busy=%b expected 0 1 %h 1",
                         c, src_ready, pcie_out_valid, pcie_out_data, busy, held);
            end
        end
        pcie_grant_in = 1'b1;
        for (int c = 0; c < 3; c++) step();
        check_drained("grant_stall");
    endtask

    task automatic test_reset_mid();
        do_reset();
        add_pkt(2, 3, 1, 1'b1);
        en = 4'b0100;
        drive();
        step();
        add_pkt(1, 3, 3, 1'b0);
        begin
            exp_t e;
            e.src = 1; e.last = 1'b0; e.data = mk_data(1, 3, 0);
            exp_q.push_back(e);
        end
        en = 4'b0110;
        drive();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check_drained("reset_mid");
        checks++;
        if (pcie_out_valid !== 1'b0 || src_ready !== '0 || busy !== 1'b0 || sent_pkt_count !== '0 ||
            dut.rr_ptr_q !== 2'd1 || dut.hp_cnt_q !== 4'd0) begin
            errors++;
            $display("FAIL reset_mid got valid=%b ready=%b busy=%b cnt=%h rr=%0d hp=%0d expected 0 0 0 0 1 0",
                     pcie_out_valid, src_ready, busy, sent_pkt_count, dut.rr_ptr_q, dut.hp_cnt_q);
        end
    endtask

    task automatic test_count_wrap();
        do_reset();
        force dut.pkt_cnt[1] = 32'hFFFF_FFFF;
        #1;
        release dut.pkt_cnt[1];
        #1;
        checks++;
        if (sent_pkt_count[32 +: 32] !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL wrap_preload got %h expected ffffffff", sent_pkt_count[32 +: 32]);
        end
        add_pkt(1, 9, 2, 1'b1);
        en = 4'b0010;
        drive();
        for (int c = 0; c < 2; c++) step();
        check_drained("count_wrap");
        checks++;
        if (sent_pkt_count[32 +: 32] !== 32'd0) begin
            errors++;
            $display("FAIL wrap_result got %h expected 0", sent_pkt_count[32 +: 32]);
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_hp_quota();
        test_round_robin();
        test_grant_stall();
        test_reset_mid();
        test_count_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
